// File: rtl/branch_resolve_stage_pkg.sv
// Shared RV32I types for the execute-stage branch resolver: control-transfer kinds,
// branch conditions and the resolver FSM states.
package branch_resolve_stage_pkg;

  typedef logic [31:0] rv32i_word;

  typedef enum logic [2:0] {
    BR_BEQ  = 3'b000,
    BR_BNE  = 3'b001,
    BR_BLT  = 3'b100,
    BR_BGE  = 3'b101,
    BR_BLTU = 3'b110,
    BR_BGEU = 3'b111
  } branch_funct3_t;

  typedef enum logic [1:0] {
    K_OTHER  = 2'd0,
    K_BRANCH = 2'd1,
    K_JAL    = 2'd2,
    K_JALR   = 2'd3
  } ctrl_kind_t;

  typedef enum logic {
    IDLE     = 1'b0,
    REDIRECT = 1'b1
  } brs_state_t;

  localparam rv32i_word LINK_OFFSET = 32'd4;

  // RV32I without the C extension needs every fetch target word aligned.
  function automatic logic is_word_aligned(input rv32i_word addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/branch_resolve_stage_cmp.sv
// Branch condition evaluator: br_en is high when the funct3 condition holds for op1/op2.
// Reserved funct3 encodings never take.
module branch_resolve_stage_cmp
  import branch_resolve_stage_pkg::*;
(
  input  logic [2:0] cmpop,
  input  rv32i_word  op1,
  input  rv32i_word  op2,
  output logic       br_en
);

  always_comb begin
    br_en = 1'b0;
    case (cmpop)
      BR_BEQ:  br_en = (op1 == op2);
      BR_BNE:  br_en = (op1 != op2);
      BR_BLT:  br_en = ($signed(op1) <  $signed(op2));
      BR_BGE:  br_en = ($signed(op1) >= $signed(op2));
      BR_BLTU: br_en = (op1 <  op2);
      BR_BGEU: br_en = (op1 >= op2);
      default: br_en = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_stage.sv
// Execute-stage branch/jump resolution: registered writeback result, fetch redirect with
// epoch-based squashing of wrong-path ops, and saturating branch statistics.
module branch_resolve_stage
  import branch_resolve_stage_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_kind,
  input  logic [2:0]       in_funct3,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_imm,
  input  logic [31:0]      in_rs1,
  input  logic [31:0]      in_rs2,
  input  logic             in_epoch,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_link,
  output logic             out_taken,
  output logic             out_exc,
  output logic             redir_valid,
  input  logic             redir_ready,
  output logic [31:0]      redir_pc,
  output logic             cur_epoch,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] taken_count
);

  brs_state_t r_state;
  brs_state_t w_state_next;
  logic       r_epoch;
  logic       r_out_valid;
  rv32i_word  r_out_link;
  logic       r_out_taken;
  logic       r_out_exc;
  rv32i_word  r_redir_pc;

  ctrl_kind_t w_kind;
  logic       w_br_en;
  rv32i_word  w_pc_target;
  rv32i_word  w_reg_target;
  rv32i_word  w_target;
  logic       w_cond;
  logic       w_aligned;
  logic       w_taken;
  logic       w_exc;
  logic       w_in_ready;
  logic       w_accept;
  logic       w_fresh;
  logic       w_redirect;

  assign w_kind = ctrl_kind_t'(in_kind);

  branch_resolve_stage_cmp u_cmp (
    .cmpop (in_funct3),
    .op1   (in_rs1),
    .op2   (in_rs2),
    .br_en (w_br_en)
  );

  assign w_pc_target  = in_pc + in_imm;
  assign w_reg_target = (in_rs1 + in_imm) & ~32'd1;
  assign w_target     = (w_kind == K_JALR) ? w_reg_target : w_pc_target;

  always_comb begin
    w_cond = 1'b0;
    case (w_kind)
      K_BRANCH:     w_cond = w_br_en;
      K_JAL,K_JALR: w_cond = 1'b1;
      default:      w_cond = 1'b0;
    endcase
  end

  // A misaligned target turns the transfer into an exception instead of a redirect.
  assign w_aligned = is_word_aligned(w_target);
  assign w_taken   = w_cond && w_aligned;
  assign w_exc     = w_cond && !w_aligned;

  assign w_in_ready = (r_state == IDLE) && (!r_out_valid || out_ready);
  assign w_accept   = in_valid && w_in_ready;
  assign w_fresh    = w_accept && (in_epoch == r_epoch);
  assign w_redirect = w_fresh && w_taken;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:     if (w_redirect)  w_state_next = REDIRECT;
      REDIRECT: if (redir_ready) w_state_next = IDLE;
      default:  w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_epoch    <= 1'b0;
      r_redir_pc <= '0;
    end else if (w_redirect) begin
      r_epoch    <= ~r_epoch;
      r_redir_pc <= w_target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_link  <= '0;
      r_out_taken <= 1'b0;
      r_out_exc   <= 1'b0;
    end else if (w_fresh) begin
      r_out_valid <= 1'b1;
      r_out_link  <= in_pc + LINK_OFFSET;
      r_out_taken <= w_taken;
      r_out_exc   <= w_exc;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Index 0 counts resolved conditional branches, index 1 the taken ones.
  logic [1:0]       w_cnt_inc;
  logic [CNT_W-1:0] r_cnt [2];

  assign w_cnt_inc[0] = w_fresh && (w_kind == K_BRANCH);
  assign w_cnt_inc[1] = w_cnt_inc[0] && w_taken;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          r_cnt[gi] <= '0;
        else if (w_cnt_inc[gi] && (r_cnt[gi] != {CNT_W{1'b1}}))
          r_cnt[gi] <= r_cnt[gi] + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  endgenerate

  assign in_ready    = w_in_ready;
  assign out_valid   = r_out_valid;
  assign out_link    = r_out_link;
  assign out_taken   = r_out_taken;
  assign out_exc     = r_out_exc;
  assign redir_valid = (r_state == REDIRECT);
  assign redir_pc    = r_redir_pc;
  assign cur_epoch   = r_epoch;
  assign br_count    = r_cnt[0];
  assign taken_count = r_cnt[1];

endmodule

// File: tb/tb_branch_resolve_stage.sv
// Self-checking bench for branch_resolve_stage: directed scenarios plus randomized ops
// checked against a behavioural model; a second instance with CNT_W=2 covers saturation.
module tb_branch_resolve_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_epoch;
  logic [1:0]  in_kind;
  logic [2:0]  in_funct3;
  logic [31:0] in_pc, in_imm, in_rs1, in_rs2;
  logic        out_valid, out_ready, out_taken, out_exc;
  logic [31:0] out_link, redir_pc;
  logic        redir_valid, redir_ready, cur_epoch;
  logic [15:0] br_count, taken_count;

  logic        in_ready2, out_valid2, out_taken2, out_exc2, redir_valid2, cur_epoch2;
  logic [31:0] out_link2, redir_pc2;
  logic [1:0]  br_count2, taken_count2;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  bit m_epoch;
  int m_br, m_tk, m_br2, m_tk2;

  always #5 clk = ~clk;

  branch_resolve_stage #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
    .in_funct3(in_funct3), .in_pc(in_pc), .in_imm(in_imm), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_epoch(in_epoch), .out_valid(out_valid), .out_ready(out_ready), .out_link(out_link),
    .out_taken(out_taken), .out_exc(out_exc), .redir_valid(redir_valid),
    .redir_ready(redir_ready), .redir_pc(redir_pc), .cur_epoch(cur_epoch),
    .br_count(br_count), .taken_count(taken_count)
  );

  branch_resolve_stage #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2), .in_kind(in_kind),
    .in_funct3(in_funct3), .in_pc(in_pc), .in_imm(in_imm), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_epoch(in_epoch), .out_valid(out_valid2), .out_ready(out_ready), .out_link(out_link2),
    .out_taken(out_taken2), .out_exc(out_exc2), .redir_valid(redir_valid2),
    .redir_ready(redir_ready), .redir_pc(redir_pc2), .cur_epoch(cur_epoch2),
    .br_count(br_count2), .taken_count(taken_count2)
  );

  task automatic model_reset();
    m_epoch = 1'b0;
    m_br = 0; m_tk = 0; m_br2 = 0; m_tk2 = 0;
  endtask

  // Computes the architectural outcome of one accepted op and advances the model.
  task automatic model_step(input int k, input int f3, input logic [31:0] pc, input logic [31:0] imm,
                            input logic [31:0] a, input logic [31:0] b, input bit ep,
                            output bit fresh, output logic [31:0] link, output bit taken,
                            output bit exc, output logic [31:0] tgt);
    bit cond;
    int sa, sb;
    sa = a;
    sb = b;
    fresh = (ep == m_epoch);
    link = pc + 32'd4;
    tgt = (k == 3) ? ((a + imm) & 32'hFFFF_FFFE) : (pc + imm);
    cond = 1'b0;
    if (k == 1) begin
      case (f3)
        0: cond = (a == b);
        1: cond = (a != b);
        4: cond = (sa < sb);
        5: cond = (sa >= sb);
        6: cond = (a < b);
        7: cond = (a >= b);
        default: cond = 1'b0;
      endcase
    end else if (k == 2 || k == 3) begin
      cond = 1'b1;
    end
    taken = cond && (tgt % 4 == 0);
    exc = cond && (tgt % 4 != 0);
    if (fresh) begin
      if (taken) m_epoch = ~m_epoch;
      if (k == 1) begin
        if (m_br < 65535) m_br++;
        if (m_br2 < 3) m_br2++;
        if (taken) begin
          if (m_tk < 65535) m_tk++;
          if (m_tk2 < 3) m_tk2++;
        end
      end
    end
  endtask

  // Presents one op and holds it until it is accepted; returns #1 after the accepting edge.
  task automatic drive_op(input int k, input int f3, input logic [31:0] pc, input logic [31:0] imm,
                          input logic [31:0] a, input logic [31:0] b, input bit ep);
    bit got = 1'b0;
    in_kind = k[1:0]; in_funct3 = f3[2:0]; in_pc = pc; in_imm = imm;
    in_rs1 = a; in_rs2 = b; in_epoch = ep; in_valid = 1'b1;
    for (int n = 0; n < 20 && !got; n++) begin
      if (in_ready) got = 1'b1;
      else begin
        @(posedge clk); #1;
        if (n == 3) begin redir_ready = 1'b1; out_ready = 1'b1; end
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL accept_timeout in_ready=%0b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    $display("op kind=%0d f3=%0d pc=%h imm=%h rs1=%h rs2=%h ep=%0b -> valid=%0b link=%h taken=%0b exc=%0b redir=%0b/%h epoch=%0b",
             k, f3, pc, imm, a, b, ep, out_valid, out_link, out_taken, out_exc, redir_valid, redir_pc, cur_epoch);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; redir_ready = 1'b1;
    in_kind = 2'd0; in_funct3 = 3'd0; in_pc = '0; in_imm = '0; in_rs1 = '0; in_rs2 = '0; in_epoch = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, redir_valid, cur_epoch, in_ready} !== 4'b0001) begin
      errors++; $display("FAIL reset_flags got %b want 0001", {out_valid, redir_valid, cur_epoch, in_ready});
    end
    checks++;
    if ({br_count, taken_count, out_link, redir_pc} !== 96'd0) begin
      errors++; $display("FAIL reset_data got %h want 0", {br_count, taken_count, out_link, redir_pc});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_beq();
    bit f, t, e; logic [31:0] l, g;
    model_step(1, 0, 32'h100, 32'h20, 32'd5, 32'd5, m_epoch, f, l, t, e, g);
    drive_op(1, 0, 32'h100, 32'h20, 32'd5, 32'd5, 1'b0);
    checks++;
    if ({out_valid, out_taken, out_exc, out_link} !== {3'b110, 32'h104}) begin
      errors++; $display("FAIL beq_result got v%0b t%0b e%0b link=%h want v1 t1 e0 link=00000104",
                         out_valid, out_taken, out_exc, out_link);
    end
    checks++;
    if ({redir_valid, redir_pc, cur_epoch} !== {1'b1, 32'h120, 1'b1}) begin
      errors++; $display("FAIL beq_redirect got %0b/%h epoch=%0b want 1/00000120 epoch=1", redir_valid, redir_pc, cur_epoch);
    end
    checks++;
    if (br_count !== 16'd1 || taken_count !== 16'd1) begin
      errors++; $display("FAIL beq_counts got %0d/%0d want 1/1", br_count, taken_count);
    end
  endtask

  task automatic test_bltu_blt();
    bit f, t, e; logic [31:0] l, g;
    model_step(1, 6, 32'h180, 32'h40, 32'hFFFF_FFFF, 32'd1, m_epoch, f, l, t, e, g);
    drive_op(1, 6, 32'h180, 32'h40, 32'hFFFF_FFFF, 32'd1, 1'b1);
    checks++;
    if ({out_valid, out_taken, redir_valid, cur_epoch} !== 4'b1001) begin
      errors++; $display("FAIL bltu_not_taken got v%0b t%0b r%0b ep%0b want 1 0 0 1", out_valid, out_taken, redir_valid, cur_epoch);
    end
    checks++;
    if (br_count !== 16'd2 || taken_count !== 16'd1) begin
      errors++; $display("FAIL bltu_counts got %0d/%0d want 2/1", br_count, taken_count);
    end
    model_step(1, 4, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1, m_epoch, f, l, t, e, g);
    drive_op(1, 4, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1, 1'b1);
    checks++;
    if ({out_taken, redir_valid, redir_pc, cur_epoch} !== {2'b11, 32'h240, 1'b0}) begin
      errors++; $display("FAIL blt_taken got t%0b r%0b pc=%h ep%0b want 1 1 00000240 0", out_taken, redir_valid, redir_pc, cur_epoch);
    end
  endtask

  task automatic test_stale();
    bit f, t, e; logic [31:0] l, g;
    int br0, tk0;
    bit ep0;
    br0 = m_br; tk0 = m_tk; ep0 = m_epoch;
    model_step(1, 0, 32'h300, 32'h8, 32'd7, 32'd7, ~m_epoch, f, l, t, e, g);
    drive_op(1, 0, 32'h300, 32'h8, 32'd7, 32'd7, ~ep0);
    checks++;
    if ({out_valid, redir_valid, cur_epoch} !== {2'b00, ep0}) begin
      errors++; $display("FAIL stale_discard got v%0b r%0b ep%0b want 0 0 %0b", out_valid, redir_valid, cur_epoch, ep0);
    end
    checks++;
    if (int'(br_count) != br0 || int'(taken_count) != tk0) begin
      errors++; $display("FAIL stale_counts got %0d/%0d want %0d/%0d", br_count, taken_count, br0, tk0);
    end
  endtask

  task automatic test_jalr_jal();
    bit f, t, e; logic [31:0] l, g;
    model_step(3, 0, 32'h400, 32'h0, 32'h205, 32'h0, m_epoch, f, l, t, e, g);
    drive_op(3, 0, 32'h400, 32'h0, 32'h205, 32'h0, m_epoch ^ t);
    checks++;
    if ({out_taken, out_exc, redir_valid, redir_pc, out_link} !== {3'b101, 32'h204, 32'h404}) begin
      errors++; $display("FAIL jalr_aligned got t%0b e%0b r%0b pc=%h link=%h want 1 0 1 00000204 00000404",
                         out_taken, out_exc, redir_valid, redir_pc, out_link);
    end
    model_step(3, 0, 32'h410, 32'h0, 32'h203, 32'h0, m_epoch, f, l, t, e, g);
    drive_op(3, 0, 32'h410, 32'h0, 32'h203, 32'h0, m_epoch);
    checks++;
    if ({out_valid, out_taken, out_exc, redir_valid} !== 4'b1010) begin
      errors++; $display("FAIL jalr_misaligned got v%0b t%0b e%0b r%0b want 1 0 1 0", out_valid, out_taken, out_exc, redir_valid);
    end
    model_step(2, 0, 32'h10, 32'h2, 32'h0, 32'h0, m_epoch, f, l, t, e, g);
    drive_op(2, 0, 32'h10, 32'h2, 32'h0, 32'h0, m_epoch);
    checks++;
    if ({out_taken, out_exc, redir_valid, cur_epoch, out_link} !== {3'b010, m_epoch, 32'h14}) begin
      errors++; $display("FAIL jal_misaligned got t%0b e%0b r%0b ep%0b link=%h want 0 1 0 %0b 00000014",
                         out_taken, out_exc, redir_valid, cur_epoch, out_link, m_epoch);
    end
  endtask

  task automatic test_redirect_hold();
    bit f, t, e; logic [31:0] l, g;
    bit ep;
    ep = m_epoch;
    redir_ready = 1'b0;
    model_step(2, 0, 32'h500, 32'h100, 32'h0, 32'h0, m_epoch, f, l, t, e, g);
    drive_op(2, 0, 32'h500, 32'h100, 32'h0, 32'h0, ep);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({in_ready, redir_valid, redir_pc} !== {2'b01, 32'h600}) begin
        errors++; $display("FAIL redir_hold%0d got rdy%0b r%0b pc=%h want 0 1 00000600", i, in_ready, redir_valid, redir_pc);
      end
    end
    redir_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({in_ready, redir_valid} !== 2'b10) begin
      errors++; $display("FAIL redir_release got rdy%0b r%0b want 1 0", in_ready, redir_valid);
    end
  endtask

  task automatic test_out_hold();
    bit f, t, e; logic [31:0] l, g;
    out_ready = 1'b0;
    model_step(0, 0, 32'h600, 32'h0, 32'h0, 32'h0, m_epoch, f, l, t, e, g);
    drive_op(0, 0, 32'h600, 32'h0, 32'h0, 32'h0, m_epoch);
    in_pc = 32'h700; in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({out_valid, in_ready, out_taken, out_link} !== {3'b100, 32'h604}) begin
        errors++; $display("FAIL out_hold%0d got v%0b rdy%0b t%0b link=%h want 1 0 0 00000604", i, out_valid, in_ready, out_taken, out_link);
      end
    end
    model_step(0, 0, 32'h700, 32'h0, 32'h0, 32'h0, m_epoch, f, l, t, e, g);
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_link} !== {1'b1, l}) begin
      errors++; $display("FAIL out_back_to_back got v%0b link=%h want 1 %h", out_valid, out_link, l);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL out_clear got v%0b want 0", out_valid);
    end
  endtask

  task automatic test_random();
    bit f, t, e; logic [31:0] l, g;
    int k, f3;
    logic [31:0] pc, imm, a, b;
    bit ep;
    for (int i = 0; i < 60; i++) begin
      k = $urandom_range(0, 3);
      f3 = $urandom_range(0, 7);
      pc = $urandom & 32'hFFFF_FFFC;
      imm = $urandom;
      if (k == 1 || $urandom_range(0, 1) == 0) imm[1:0] = 2'b00;
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : (($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 9)) : $urandom);
      ep = ($urandom_range(0, 3) == 0) ? ~m_epoch : m_epoch;
      redir_ready = 1'($urandom_range(0, 1));
      model_step(k, f3, pc, imm, a, b, ep, f, l, t, e, g);
      drive_op(k, f3, pc, imm, a, b, ep);
      checks++;
      if (f && {out_valid, out_link, out_taken, out_exc} !== {1'b1, l, t, e}) begin
        errors++; $display("FAIL rand%0d_result got v%0b link=%h t%0b e%0b want 1 %h %0b %0b",
                           i, out_valid, out_link, out_taken, out_exc, l, t, e);
      end else if (!f && out_valid !== 1'b0) begin
        errors++; $display("FAIL rand%0d_stale got v%0b want 0", i, out_valid);
      end
      checks++;
      if (redir_valid !== (f && t) || (f && t && redir_pc !== g) || cur_epoch !== m_epoch) begin
        errors++; $display("FAIL rand%0d_redirect got r%0b pc=%h ep%0b want %0b %h %0b",
                           i, redir_valid, redir_pc, cur_epoch, f && t, g, m_epoch);
      end
      checks++;
      if (int'(br_count) != m_br || int'(taken_count) != m_tk) begin
        errors++; $display("FAIL rand%0d_counts got %0d/%0d want %0d/%0d", i, br_count, taken_count, m_br, m_tk);
      end
    end
    redir_ready = 1'b1;
  endtask

  task automatic test_reset_mid_redirect();
    bit f, t, e; logic [31:0] l, g;
    redir_ready = 1'b0;
    model_step(1, 0, 32'h900, 32'h10, 32'd3, 32'd3, m_epoch, f, l, t, e, g);
    drive_op(1, 0, 32'h900, 32'h10, 32'd3, 32'd3, m_epoch ^ t);
    checks++;
    if (redir_valid !== 1'b1) begin
      errors++; $display("FAIL pre_reset_redirect got %0b want 1", redir_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({redir_valid, out_valid, cur_epoch, br_count, taken_count} !== 35'd0) begin
      errors++; $display("FAIL reset_mid_redirect got r%0b v%0b ep%0b cnt=%0d/%0d want all 0",
                         redir_valid, out_valid, cur_epoch, br_count, taken_count);
    end
    model_reset();
    redir_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_saturation();
    bit f, t, e; logic [31:0] l, g;
    for (int i = 0; i < 5; i++) begin
      model_step(1, 0, 32'hA00 + 32'(i * 16), 32'h8, 32'd1, 32'd1, m_epoch, f, l, t, e, g);
      drive_op(1, 0, 32'hA00 + 32'(i * 16), 32'h8, 32'd1, 32'd1, m_epoch ^ t);
    end
    @(posedge clk); #1;
    checks++;
    if (int'(taken_count2) != m_tk2 || int'(br_count2) != m_br2) begin
      errors++; $display("FAIL sat_cnt2 got %0d/%0d want %0d/%0d", br_count2, taken_count2, m_br2, m_tk2);
    end
    checks++;
    if (int'(taken_count) != m_tk || int'(br_count) != m_br) begin
      errors++; $display("FAIL sat_cnt16 got %0d/%0d want %0d/%0d", br_count, taken_count, m_br, m_tk);
    end
    checks++;
    if (cur_epoch2 !== m_epoch || redir_valid2 !== 1'b0) begin
      errors++; $display("FAIL sat_epoch got ep%0b r%0b want %0b 0", cur_epoch2, redir_valid2, m_epoch);
    end
  endtask

  initial begin
    test_reset();
    test_beq();
    test_bltu_blt();
    test_stale();
    test_jalr_jal();
    test_redirect_hold();
    test_out_hold();
    test_random();
    test_reset_mid_redirect();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
